// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and types for the interrupt pending controller
package irq_pkg;

    localparam int N_SRC = 16;
    localparam int IDX_W = $clog2(N_SRC);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } irq_state_t;

    typedef logic [N_SRC-1:0] irq_vec_t;

endpackage

// File: rtl/irq_edge_det.sv
// rtl/irq_edge_det.sv - rising-edge detector for the request lines
module irq_edge_det
    import irq_pkg::*;
(
    input  logic     clk,
    input  irq_vec_t irq_in,
    output irq_vec_t rise
);

    irq_vec_t irq_d;

    // Loaded unconditionally, reset included, so a line held high through reset never fires.
    always_ff @(posedge clk) begin
        irq_d <= irq_in;
    end

    assign rise = irq_in & ~irq_d;

endmodule

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - pending register and handshake front end for an external 16-4 encoder
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] irq_mask,
    output logic [N_SRC-1:0] enc_a,
    output logic             enc_ei,
    input  logic [IDX_W-1:0] enc_l,
    input  logic             enc_gs,
    input  logic             enc_eo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_SRC-1:0] pending,
    output logic             enc_err
);

    irq_state_t       state, state_nxt;
    irq_vec_t         rise;
    irq_vec_t         clr;
    irq_vec_t         pending_nxt;
    logic             out_valid_nxt;
    logic [IDX_W-1:0] out_idx_nxt;
    logic             enc_err_nxt;

    irq_edge_det u_edge_det (
        .clk    (clk),
        .irq_in (irq_in),
        .rise   (rise)
    );

    assign enc_a  = pending & ~irq_mask;
    assign enc_ei = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        out_idx_nxt   = out_idx;
        enc_err_nxt   = enc_err;
        clr           = '0;
        case (state)
            IDLE: begin
                if ((enc_gs == enc_eo) || (enc_gs && !enc_a[enc_l])) begin
                    enc_err_nxt = 1'b1;
                end
                if (enc_gs) begin
                    out_idx_nxt   = enc_l;
                    out_valid_nxt = 1'b1;
                    state_nxt     = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    clr[out_idx]  = 1'b1;
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A rise on the bit being cleared wins, so the new request survives.
        pending_nxt = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            enc_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            out_valid <= out_valid_nxt;
            out_idx   <= out_idx_nxt;
            enc_err   <= enc_err_nxt;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - scoreboard bench for irq_pending_ctrl with a 16-4 encoder in the loop
module tb_irq_pending_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] irq_in = '0;
    logic [15:0] irq_mask = '0;
    logic [15:0] enc_a;
    logic        enc_ei;
    logic [3:0]  enc_l;
    logic        enc_gs;
    logic        enc_eo;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_idx;
    logic [15:0] pending;
    logic        enc_err;

    logic [3:0]  l_m;
    logic        gs_m, eo_m;
    logic        stub_en = 1'b0;
    logic        chk_en  = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_pend = '0;
    logic [15:0] m_irq_d = '0;
    bit          m_busy = 1'b0;
    int          m_idx = 0;
    int          exp_q[$];

    irq_pending_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .irq_mask  (irq_mask),
        .enc_a     (enc_a),
        .enc_ei    (enc_ei),
        .enc_l     (enc_l),
        .enc_gs    (enc_gs),
        .enc_eo    (enc_eo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .enc_err   (enc_err)
    );

    always #5 clk = ~clk;

    // encoder_164 behaviour: highest set input, gated by EI; stub overrides to GS=EO=1
    always_comb begin
        l_m  = 4'd0;
        gs_m = 1'b0;
        eo_m = 1'b0;
        if (enc_ei) begin
            if (enc_a != 16'h0) gs_m = 1'b1;
            else                eo_m = 1'b1;
            for (int i = 0; i < 16; i++) if (enc_a[i]) l_m = 4'(i);
        end
    end
    assign enc_gs = stub_en ? 1'b1 : gs_m;
    assign enc_eo = stub_en ? 1'b1 : eo_m;
    assign enc_l  = stub_en ? 4'd0 : l_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int highest(input logic [15:0] v);
        int h = -1;
        for (int i = 0; i < 16; i++) if (v[i]) h = i;
        return h;
    endfunction

    // Drive one clock of inputs and advance the reference model across that edge.
    task automatic cycle(input logic [15:0] irq, input logic [15:0] msk, input logic rdy, input logic r);
        logic [15:0] n_pend;
        bit          n_busy;
        int          n_idx;
        int          h;
        bit          push;
        irq_in    = irq;
        irq_mask  = msk;
        out_ready = rdy;
        rst       = r;
        push   = 1'b0;
        n_pend = m_pend;
        n_busy = m_busy;
        n_idx  = m_idx;
        if (r) begin
            n_pend = '0;
            n_busy = 1'b0;
            n_idx  = 0;
        end else begin
            if (m_busy) begin
                if (rdy) begin
                    n_pend[m_idx] = 1'b0;
                    n_busy = 1'b0;
                end
            end else begin
                h = highest(m_pend & ~msk);
                if (h >= 0) begin
                    n_busy = 1'b1;
                    n_idx  = h;
                    push   = 1'b1;
                end
            end
            n_pend = n_pend | (irq & ~m_irq_d);
        end
        @(posedge clk);
        #1;
        if (r) exp_q.delete();
        m_pend  = n_pend;
        m_busy  = n_busy;
        m_idx   = n_idx;
        m_irq_d = irq;
        if (push) exp_q.push_back(n_idx);
    endtask

    task automatic drain(input logic [15:0] irq);
        int n = 0;
        while ((m_busy || m_pend != 16'h0 || exp_q.size() != 0) && n < 60) begin
            cycle(irq, 16'h0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0h still outstanding, required 0", pending);
        end
    endtask

    always @(negedge clk) begin
        int e;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_busy));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("enc_err_clean", 32'(enc_err), 32'd0);
            if (m_busy) chk("out_idx_hold", 32'(out_idx), 32'(m_idx));
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake_unexpected: got idx %0d, required none", out_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("handshake_idx", 32'(out_idx), 32'(e));
                end
            end
        end
    end

    initial begin
        logic [15:0] ri;
        logic [15:0] rm;
        int          n;

        cycle(16'h0, 16'h0, 1'b0, 1'b1);
        cycle(16'h0, 16'h0, 1'b0, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_enc_err", 32'(enc_err), 32'd0);
        chk_en = 1'b1;

        // 1: single request, two-cycle latency
        cycle(16'h0001, 16'h0, 1'b0, 1'b0);
        chk("t1_pending_set", 32'(pending), 32'h0001);
        chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
        cycle(16'h0001, 16'h0, 1'b0, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_idx", 32'(out_idx), 32'd0);
        cycle(16'h0001, 16'h0, 1'b1, 1'b0);
        chk("t1_cleared", 32'(pending), 32'h0);
        cycle(16'h0000, 16'h0, 1'b0, 1'b0);

        // 2: two simultaneous requests, highest first
        cycle(16'h0404, 16'h0, 1'b1, 1'b0);
        chk("t2_pending", 32'(pending), 32'h0404);
        cycle(16'h0404, 16'h0, 1'b1, 1'b0);
        chk("t2_first_idx", 32'(out_idx), 32'd10);
        cycle(16'h0404, 16'h0, 1'b1, 1'b0);
        chk("t2_pending_after_first", 32'(pending), 32'h0004);
        cycle(16'h0404, 16'h0, 1'b1, 1'b0);
        chk("t2_second_idx", 32'(out_idx), 32'd2);
        cycle(16'h0404, 16'h0, 1'b1, 1'b0);
        chk("t2_pending_empty", 32'(pending), 32'h0);
        cycle(16'h0000, 16'h0, 1'b0, 1'b0);

        // 3: masked source latches but is hidden until unmasked
        cycle(16'h0100, 16'h0100, 1'b1, 1'b0);
        chk("t3_pending", 32'(pending), 32'h0100);
        for (int i = 0; i < 3; i++) cycle(16'h0100, 16'h0100, 1'b1, 1'b0);
        chk("t3_masked_no_valid", 32'(out_valid), 32'd0);
        cycle(16'h0100, 16'h0000, 1'b1, 1'b0);
        chk("t3_unmasked_idx", 32'(out_idx), 32'd8);
        drain(16'h0000);

        // 4: consumer stalls; a later request waits for the handshake
        cycle(16'h0010, 16'h0, 1'b0, 1'b0);
        cycle(16'h0010, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle((i == 2) ? 16'h8010 : ((i > 2) ? 16'h8010 : 16'h0010), 16'h0, 1'b0, 1'b0);
            chk("t4_idx_stable", 32'(out_idx), 32'd4);
        end
        cycle(16'h8010, 16'h0, 1'b1, 1'b0);
        cycle(16'h8010, 16'h0, 1'b1, 1'b0);
        chk("t4_next_idx", 32'(out_idx), 32'd15);
        drain(16'h0000);

        // 5: same bit re-rises on its own handshake edge
        cycle(16'h0008, 16'h0, 1'b0, 1'b0);
        n = 0;
        cycle(16'h0000, 16'h0, 1'b0, 1'b0);
        while (!m_busy && n < 10) begin
            cycle(16'h0000, 16'h0, 1'b0, 1'b0);
            n++;
        end
        cycle(16'h0008, 16'h0, 1'b1, 1'b0);
        chk("t5_bit_kept", 32'(pending), 32'h0008);
        drain(16'h0008);
        cycle(16'h0000, 16'h0, 1'b0, 1'b0);

        // random traffic
        ri = '0;
        for (int i = 0; i < 600; i++) begin
            ri = ri ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            rm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            cycle(ri, rm, ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
        end
        drain(ri);

        // 6: reset while VALID with all lines held high
        cycle(16'h0000, 16'h0, 1'b0, 1'b0);
        cycle(16'hFFFF, 16'h0, 1'b0, 1'b0);
        cycle(16'hFFFF, 16'h0, 1'b0, 1'b0);
        chk("t6_valid_before_rst", 32'(out_valid), 32'd1);
        cycle(16'hFFFF, 16'h0, 1'b1, 1'b1);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_pending", 32'(pending), 32'h0);
        for (int i = 0; i < 4; i++) cycle(16'hFFFF, 16'h0, 1'b1, 1'b0);
        chk("t6_no_refire", 32'(out_valid), 32'd0);
        chk_en = 1'b0;
        stub_en = 1'b1;
        cycle(16'hFFFF, 16'h0, 1'b1, 1'b0);
        chk("t6_enc_err_set", 32'(enc_err), 32'd1);
        stub_en = 1'b0;
        cycle(16'hFFFF, 16'h0, 1'b1, 1'b0);
        cycle(16'hFFFF, 16'h0, 1'b1, 1'b0);
        chk("t6_enc_err_sticky", 32'(enc_err), 32'd1);
        cycle(16'hFFFF, 16'h0, 1'b1, 1'b1);
        chk("t6_enc_err_rst", 32'(enc_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
